fp32_maxpool2x2: RTL and testbench
==================================

// Module: fp32_maxpool2x2
// PURPOSE
//   Downstream stage of the IEEE754 convolution engine. Consumes the engine's serial output (out, strobed by done) as a row-major
//   feature map of cfg_w x cfg_h fp32 words. Applies 2x2 max pooling with stride 2 and emits one fp32 result per complete window.
//   A half-row line buffer holds the partial maxima of the even rows.
// PARAMETERS
//   MAX_W   64  largest supported input map width (line buffer depth = MAX_W/2)
//   CNT_W   8   width of cfg_w/cfg_h and the internal row/col counters
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   start       in   1      one-cycle pulse; latches cfg_w/cfg_h and begins a frame
//   cfg_w       in   CNT_W  input map width (2..MAX_W)
//   cfg_h       in   CNT_W  input map height (>=2)
//   in_data     in   32     fp32 element from the conv stage (its out)
//   in_valid    in   1      element strobe (the conv stage's done)
//   out_data    out  32     pooled fp32 result, registered
//   out_valid   out  1      one-cycle strobe qualifying out_data
//   frame_done  out  1      one-cycle pulse after the last input element of a frame
//   busy        out  1      high from the cycle after an accepted start until frame_done
// BEHAVIOUR
//   - Reset: out_data=0, out_valid=0, frame_done=0, busy=0, FSM=IDLE, counters=0. Line buffer contents are don't-care.
//   - FSM: IDLE -start & cfg_w>=2 & cfg_w<=MAX_W & cfg_h>=2-> EVEN_ROW. EVEN_ROW -row end-> ODD_ROW.
//     ODD_ROW -row end-> EVEN_ROW, or IDLE if it was the last row. EVEN_ROW -row end of last row (odd cfg_h)-> IDLE.
//   - start with illegal cfg is ignored (busy stays 0). start while busy is ignored. in_valid in IDLE is ignored.
//   - in_valid needs no gaps or back-pressure; one element is accepted per strobed cycle; col/row counters advance only on in_valid.
//   - EVEN_ROW: even col -> hold the element in a pair register. Odd col -> linebuf[col/2] = max(pair, in).
//   - ODD_ROW: even col -> pair register. Odd col -> result = max(linebuf[col/2], pair, in); out_valid=1 on the next cycle.
//   - Latency: out_valid asserts exactly 1 cycle after the window's bottom-right element is accepted.
//   - Odd cfg_w: the last column is discarded. Odd cfg_h: the last row is consumed but produces no outputs.
//   - frame_done asserts 1 cycle after the final element (row cfg_h-1, col cfg_w-1) is accepted.
//     If that element completes a window, frame_done coincides with the last out_valid. busy drops in the same cycle.
//   - Compare order (fp32_max): sign-magnitude total order, so -0 < +0 and -inf < every finite value < +inf.
//     Any NaN in a window forces the result to 32'h7FC00000 (sticky flag per window, kept in a linebuf side bit).
//   - Denormals are compared as-is, with no flushing.
//   - rst mid-frame: returns immediately to the reset state. The partial frame is lost and no frame_done is issued.
// CONFIGURATION
//   `RELU_EN defined: each in_data is passed through ReLU before pooling (sign=1 and not NaN -> 32'h00000000; -0 -> +0).
//     NaN is still propagated. All-negative windows yield 32'h00000000.
//   `RELU_EN undefined: raw values are pooled. All-negative windows yield the largest (least negative) value.
// STRUCTURE
//   - Package fp32_pkg: typedef logic [31:0] fp32_t; FP_QNAN=32'h7FC00000; FP_POS_ZERO=32'h0; function is_nan(fp32_t).
//     The FSM state enum (IDLE, EVEN_ROW, ODD_ROW) also goes in the package.
//   - Sub-module fp32_max: combinational, ports a, b -> y, nan_o. It is instantiated twice (pair max and column max).
//   - The line buffer is an inferred register array of MAX_W/2 x 33 bits (value + NaN flag).
// TESTING
//   1. 2x2 map BFC00000, BF800000, C0200000, C0600000 (RELU_EN off) -> one out_valid with BF800000 (-1.0), frame_done on the same cycle.
//   2. The same map with RELU_EN on -> out_data 00000000.
//   3. 4x4 map 1.0..16.0 (3F800000..41800000) -> 40C00000, 41000000, 41600000, 41800000 in order, then frame_done.
//   4. 5x3 map, all elements 3F800000 -> exactly 2 outputs of 3F800000. The last column and last row produce nothing;
//      frame_done comes 1 cycle after the 15th element.
//   5. 2x2 map with one element 7F800001 (NaN) and others 40000000 -> 7FC00000. Map {80000000, 00000000, 80000000, 80000000}
//      with RELU_EN off -> 00000000.
//   6. 4x4 frame with random in_valid gaps; rst pulsed after element 6; start ignored mid-frame -> no out_valid, busy=0,
//      no frame_done after rst. A fresh 2x2 frame then runs correctly.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared fp32 types, constants and helpers for the max-pooling stage.
package fp32_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP_QNAN     = 32'h7FC0_0000;
  localparam fp32_t FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2
  } pool_state_t;

  function automatic logic is_nan(input fp32_t x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

  // Negative non-NaN values (including -0) clamp to +0; NaN passes through.
  function automatic fp32_t relu(input fp32_t x);
    return (x[31] && !is_nan(x)) ? FP_POS_ZERO : x;
  endfunction

endpackage

// File: rtl/fp32_max.sv
// Combinational fp32 max under sign-magnitude total order; any NaN input yields quiet NaN.
module fp32_max
  import fp32_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t y,
  output logic  nan_o
);

  logic [31:0] w_ka;
  logic [31:0] w_kb;

  // Map to unsigned keys: negatives invert, positives set the top bit, so -0 < +0.
  assign w_ka  = a[31] ? ~a : {1'b1, a[30:0]};
  assign w_kb  = b[31] ? ~b : {1'b1, b[30:0]};
  assign nan_o = is_nan(a) | is_nan(b);
  assign y     = nan_o ? FP_QNAN : ((w_ka >= w_kb) ? a : b);

endmodule

// File: rtl/fp32_maxpool2x2.sv
// 2x2 stride-2 fp32 max pooling over a serial row-major feature map.
// Optional RELU_EN define applies ReLU to each input element before pooling.
module fp32_maxpool2x2
  import fp32_pkg::*;
#(
  parameter int MAX_W = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_w,
  input  logic [CNT_W-1:0] cfg_h,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic [31:0]      out_data,
  output logic             out_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int LB_D  = MAX_W / 2;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
  localparam logic [CNT_W-1:0] MAX_W_C = CNT_W'(MAX_W);

  pool_state_t      r_state;
  logic [CNT_W-1:0] r_w;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  fp32_t            r_pair;
  logic [32:0]      r_lb [LB_D];
  fp32_t            r_out_data;
  logic             r_out_valid;
  logic             r_frame_done;
  logic             r_busy;

  fp32_t            w_in;
  logic             w_cfg_ok;
  logic             w_accept;
  logic             w_row_end;
  logic             w_last_row;
  logic [LB_AW-1:0] w_lb_idx;
  logic [32:0]      w_lb_rd;
  fp32_t            w_pair_y;
  logic             w_pair_nan;
  fp32_t            w_col_y;
  logic             w_col_nan;
  logic             w_win_nan;

`ifdef RELU_EN
  assign w_in = relu(in_data);
`else
  assign w_in = in_data;
`endif

  assign w_cfg_ok   = (cfg_w >= CNT_W'(2)) && (cfg_w <= MAX_W_C) && (cfg_h >= CNT_W'(2));
  assign w_accept   = in_valid && (r_state != IDLE);
  assign w_row_end  = (r_col == r_w - CNT_W'(1));
  assign w_last_row = (r_row == r_h - CNT_W'(1));
  assign w_lb_idx   = r_col[LB_AW:1];
  assign w_lb_rd    = r_lb[w_lb_idx];
  assign w_win_nan  = w_lb_rd[32] | w_col_nan;

  fp32_max u_pair_max (
    .a     (r_pair),
    .b     (w_in),
    .y     (w_pair_y),
    .nan_o (w_pair_nan)
  );

  fp32_max u_col_max (
    .a     (w_lb_rd[31:0]),
    .b     (w_pair_y),
    .y     (w_col_y),
    .nan_o (w_col_nan)
  );

  // Line buffer carries no reset; each entry is written before it is read in a frame.
  always_ff @(posedge clk) begin
    if (w_accept && (r_state == EVEN_ROW) && r_col[0]) begin
      r_lb[w_lb_idx] <= {w_pair_nan, w_pair_y};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_w          <= '0;
      r_h          <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_pair       <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && w_cfg_ok) begin
            r_w     <= cfg_w;
            r_h     <= cfg_h;
            r_col   <= '0;
            r_row   <= '0;
            r_busy  <= 1'b1;
            r_state <= EVEN_ROW;
          end
        end
        EVEN_ROW, ODD_ROW: begin
          if (in_valid) begin
            if (!r_col[0]) begin
              r_pair <= w_in;
            end else if (r_state == ODD_ROW) begin
              r_out_data  <= w_win_nan ? FP_QNAN : w_col_y;
              r_out_valid <= 1'b1;
            end
            if (w_row_end) begin
              r_col <= '0;
              r_row <= r_row + CNT_W'(1);
              if (w_last_row) begin
                r_state      <= IDLE;
                r_busy       <= 1'b0;
                r_frame_done <= 1'b1;
              end else begin
                r_state <= (r_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
              end
            end else begin
              r_col <= r_col + CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_fp32_maxpool2x2.sv
// Directed, table-driven bench for fp32_maxpool2x2 (expected values follow the RELU_EN define).
module tb_fp32_maxpool2x2;

  typedef struct {
    string             name;
    int                w;
    int                h;
    int                n_in;
    int                n_exp;
    logic [15:0][31:0] din;
    logic [3:0][31:0]  exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_w;
  logic [7:0]  cfg_h;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        frame_done;
  logic        busy;

  int          n_chk;
  int          n_fail;
  int          fd_cnt;
  logic [31:0] q_out[$];
  vec_t        tbl[$];
  logic [31:0] f16 [16];

  fp32_maxpool2x2 #(.MAX_W(64), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_w      (cfg_w),
    .cfg_h      (cfg_h),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample();
    if (out_valid) q_out.push_back(out_data);
    if (frame_done) fd_cnt++;
  endtask

  task automatic add2x2(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.name = name; v.w = 2; v.h = 2; v.n_in = 4; v.n_exp = 1;
    v.din = '0; v.exp = '0;
    v.din[0] = a; v.din[1] = b; v.din[2] = c; v.din[3] = d;
    v.exp[0] = e;
    tbl.push_back(v);
  endtask

  task automatic run_frame(input vec_t v, input bit gaps);
    logic fd_last;
    q_out.delete();
    fd_cnt  = 0;
    fd_last = 1'b0;
    start = 1'b1; cfg_w = 8'(v.w); cfg_h = 8'(v.h);
    @(negedge clk);
    start = 1'b0;
    check({v.name, " busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < v.n_in; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(negedge clk); sample(); end
      in_data = v.din[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      sample();
      if (i == v.n_in - 1) fd_last = frame_done;
    end
    check({v.name, " frame_done_timing"}, 32'(fd_last), 32'd1);
    check({v.name, " busy_at_end"}, 32'(busy), 32'd0);
    repeat (3) begin @(negedge clk); sample(); end
    check({v.name, " out_count"}, 32'(q_out.size()), 32'(v.n_exp));
    check({v.name, " frame_done_count"}, 32'(fd_cnt), 32'd1);
    for (int k = 0; k < v.n_exp; k++) begin
      check($sformatf("%s out%0d", v.name, k), (k < q_out.size()) ? q_out[k] : 32'hxxxx_xxxx, v.exp[k]);
    end
  endtask

  initial begin
    vec_t v;
    n_chk = 0; n_fail = 0; fd_cnt = 0;
    rst = 1'b1; start = 1'b0; cfg_w = '0; cfg_h = '0; in_data = '0; in_valid = 1'b0;

    f16 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
            32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
            32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

`ifdef RELU_EN
    add2x2("neg2x2", 32'hBFC00000, 32'hBF800000, 32'hC0200000, 32'hC0600000, 32'h00000000);
    add2x2("negden", 32'hFF800000, 32'h80000001, 32'h80800000, 32'hFF7FFFFF, 32'h00000000);
`else
    add2x2("neg2x2", 32'hBFC00000, 32'hBF800000, 32'hC0200000, 32'hC0600000, 32'hBF800000);
    add2x2("negden", 32'hFF800000, 32'h80000001, 32'h80800000, 32'hFF7FFFFF, 32'h80000001);
`endif
    add2x2("nan2x2", 32'h40000000, 32'h7F800001, 32'h40000000, 32'h40000000, 32'h7FC00000);
    add2x2("zeros",  32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000);
    add2x2("inf",    32'hFF800000, 32'h00000001, 32'h80000001, 32'h7F800000, 32'h7F800000);

    v.name = "map4x4"; v.w = 4; v.h = 4; v.n_in = 16; v.n_exp = 4; v.din = '0; v.exp = '0;
    for (int i = 0; i < 16; i++) v.din[i] = f16[i];
    v.exp[0] = 32'h40C00000; v.exp[1] = 32'h41000000; v.exp[2] = 32'h41600000; v.exp[3] = 32'h41800000;
    tbl.push_back(v);

    v.name = "map5x3"; v.w = 5; v.h = 3; v.n_in = 15; v.n_exp = 2; v.din = '0; v.exp = '0;
    for (int i = 0; i < 15; i++) v.din[i] = 32'h3F800000;
    v.exp[0] = 32'h3F800000; v.exp[1] = 32'h3F800000;
    tbl.push_back(v);

    #1;
    check("reset out_data", out_data, 32'h0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Illegal configurations must leave the block idle.
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      cfg_w = (i == 0) ? 8'd1 : (i == 1) ? 8'd65 : (i == 2) ? 8'd4 : 8'd0;
      cfg_h = (i == 2) ? 8'd1 : 8'd4;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("illegal_cfg%0d busy", i), 32'(busy), 32'd0);
    end

    for (int t = 0; t < tbl.size(); t++) run_frame(tbl[t], 1'b0);
    run_frame(tbl[5], 1'b1);

    // Mid-frame start ignored, then reset after the sixth element.
    q_out.delete(); fd_cnt = 0;
    start = 1'b1; cfg_w = 8'd4; cfg_h = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 2)) begin @(negedge clk); sample(); end
      in_data = f16[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      sample();
      if (i == 1) begin
        start = 1'b1; cfg_w = 8'd2; cfg_h = 8'd2;
        @(negedge clk);
        start = 1'b0;
        sample();
      end
    end
    check("midframe out_count", 32'(q_out.size()), 32'd1);
    check("midframe out0", (q_out.size() > 0) ? q_out[0] : 32'hxxxx_xxxx, 32'h40C00000);
    check("midframe no_frame_done", 32'(fd_cnt), 32'd0);
    check("midframe busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst out_data", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    q_out.delete(); fd_cnt = 0;
    for (int i = 6; i < 16; i++) begin
      in_data = f16[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      sample();
    end
    repeat (3) begin @(negedge clk); sample(); end
    check("postrst no_out", 32'(q_out.size()), 32'd0);
    check("postrst no_frame_done", 32'(fd_cnt), 32'd0);
    check("postrst busy", 32'(busy), 32'd0);

    v = tbl[0];
    v.name = "fresh2x2";
    run_frame(v, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
